// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and helpers for the tristate bus arbiter.
// Index fields are sized for the largest supported requester count.
package tri_arb_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 8;
   localparam int MAX_NREQ  = 8;
   localparam int IDX_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_TURN  = 2'd3
   } state_t;

   function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return MAX_NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Requester-side handshake bundle of the arbiter.
// The master side is the requester group; the slave side is the arbiter.
interface tri_bus_arbiter_if
   import tri_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
);
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       wr;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      rdata;
   logic                  rvalid;
   logic                  busy;

   modport master (
      output req, wr, wdata,
      input  gnt, ack, rdata, rvalid, busy
   );

   modport slave (
      input  req, wr, wdata,
      output gnt, ack, rdata, rvalid, busy
   );
endinterface

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after i_ptr wins,
// measured as the smallest rotational distance from i_ptr+1.
module rr_pick
   import tri_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_win,
   output logic             o_valid
);
   always_comb begin
      int w_best;
      int w_dist;
      o_win   = '0;
      o_valid = 1'b0;
      w_best  = NREQ;
      w_dist  = 0;
      for (int j = 0; j < NREQ; j++) begin
         w_dist = (j - int'(i_ptr) - 1 + 2 * NREQ) % NREQ;
         if (i_req[j] && (w_dist < w_best)) begin
            w_best  = w_dist;
            o_win   = IDX_W'(j);
            o_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tristate bus: writes drive the bus for one
// cycle followed by a turnaround cycle; reads release the bus and sample it.
module tri_bus_arbiter
   import tri_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   tri_bus_arbiter_if.slave     arb,
   inout  wire  [WIDTH-1:0]     bus
);
   state_t            r_state, w_state_next;
   logic [NREQ-1:0]   r_gnt, w_gnt_next;
   logic [NREQ-1:0]   r_ack, w_ack_next;
   logic              r_rvalid, w_rvalid_next;
   logic [WIDTH-1:0]  r_rdata, w_rdata_next;
   logic [WIDTH-1:0]  r_dlat, w_dlat_next;
   logic [IDX_W-1:0]  r_owner, w_owner_next;
   logic [IDX_W-1:0]  r_ptr, w_ptr_next;

   logic [NREQ-1:0]   w_req_eff;
   logic [IDX_W-1:0]  w_win;
   logic              w_valid;
   logic [NREQ-1:0]   w_win_oh;
   logic [NREQ-1:0]   w_owner_oh;
   logic [WIDTH-1:0]  w_wdata_arr [NREQ];
   logic [WIDTH-1:0]  w_win_wdata;
   logic              w_oe;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign w_wdata_arr[gi] = arb.wdata[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // The requester being acked this cycle still holds req; keep it out.
   assign w_req_eff  = arb.req & ~r_ack;
   assign w_win_oh   = NREQ'(onehot(w_win));
   assign w_owner_oh = NREQ'(onehot(r_owner));

   rr_pick #(.NREQ(NREQ)) u_pick (
      .i_req   (w_req_eff),
      .i_ptr   (r_ptr),
      .o_win   (w_win),
      .o_valid (w_valid)
   );

   always_comb begin
      w_win_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win_oh[i]) w_win_wdata = w_wdata_arr[i];
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_gnt_next    = r_gnt;
      w_ack_next    = '0;
      w_rvalid_next = 1'b0;
      w_rdata_next  = r_rdata;
      w_dlat_next   = r_dlat;
      w_owner_next  = r_owner;
      w_ptr_next    = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_gnt_next   = w_win_oh;
               w_owner_next = w_win;
               w_ptr_next   = w_win;
               w_dlat_next  = w_win_wdata;
               w_state_next = (|(arb.wr & w_win_oh)) ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            w_gnt_next   = '0;
            w_ack_next   = w_owner_oh;
            w_state_next = ST_TURN;
         end
         ST_TURN: begin
            w_state_next = ST_IDLE;
         end
         ST_READ: begin
            w_rdata_next  = bus;
            w_gnt_next    = '0;
            w_ack_next    = w_owner_oh;
            w_rvalid_next = 1'b1;
            w_state_next  = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_ack    <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_dlat   <= '0;
         r_owner  <= '0;
         r_ptr    <= IDX_W'(NREQ - 1);
      end else begin
         r_state  <= w_state_next;
         r_gnt    <= w_gnt_next;
         r_ack    <= w_ack_next;
         r_rvalid <= w_rvalid_next;
         r_rdata  <= w_rdata_next;
         r_dlat   <= w_dlat_next;
         r_owner  <= w_owner_next;
         r_ptr    <= w_ptr_next;
      end
   end

   // Enable decodes straight from the state register so reset drops it at once.
   assign w_oe = (r_state == ST_WRITE);
   assign bus  = w_oe ? r_dlat : {WIDTH{1'bz}};

   assign arb.gnt    = r_gnt;
   assign arb.ack    = r_ack;
   assign arb.rdata  = r_rdata;
   assign arb.rvalid = r_rvalid;
   assign arb.busy   = (r_state != ST_IDLE);
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter; the bench drives a known pattern on the
// bus whenever the arbiter must be released, so contention shows as a bad value.
module tb_tri_bus_arbiter;
   logic       clk;
   logic       reset;
   logic       tb_oe;
   logic [7:0] tb_drv;
   wire  [7:0] bus;
   int         errors = 0;
   int         checks = 0;

   tri_bus_arbiter_if #(.NREQ(4), .WIDTH(8)) arb ();

   tri_bus_arbiter #(.NREQ(4), .WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (arb),
      .bus   (bus)
   );

   assign bus = tb_oe ? tb_drv : 8'hzz;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (arb.gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b want 0000", arb.gnt); end
      checks++; if (arb.ack !== 4'b0000) begin errors++; $display("FAIL rst_ack: got %b want 0000", arb.ack); end
      checks++; if (arb.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", arb.rvalid); end
      checks++; if (arb.rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", arb.rdata); end
      checks++; if (arb.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", arb.busy); end
      checks++; if (bus !== 8'h5A) begin errors++; $display("FAIL rst_bus: got %h want 5a", bus); end
      step();
      reset = 1'b0;
      step();
      checks++; if (arb.busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got busy %b want 0", arb.busy); end
      $display("reset done");
   endtask

   task automatic test_write();
      arb.req = 4'b0001; arb.wr = 4'b0001; arb.wdata = 32'h000000A5;
      tb_oe = 1'b1; tb_drv = 8'h5A;
      #1;
      checks++; if (bus !== 8'h5A) begin errors++; $display("FAIL wr_c0_bus: got %h want 5a", bus); end
      tb_oe = 1'b0;
      step();
      checks++; if (arb.gnt !== 4'b0001) begin errors++; $display("FAIL wr_c1_gnt: got %b want 0001", arb.gnt); end
      checks++; if (arb.busy !== 1'b1) begin errors++; $display("FAIL wr_c1_busy: got %b want 1", arb.busy); end
      checks++; if (bus !== 8'hA5) begin errors++; $display("FAIL wr_c1_bus: got %h want a5", bus); end
      checks++; if (dut.w_oe !== 1'b1) begin errors++; $display("FAIL wr_c1_oe: got %b want 1", dut.w_oe); end
      step();
      tb_oe = 1'b1;
      #1;
      checks++; if (bus !== 8'h5A) begin errors++; $display("FAIL wr_c2_bus: got %h want 5a", bus); end
      checks++; if (arb.ack !== 4'b0001) begin errors++; $display("FAIL wr_c2_ack: got %b want 0001", arb.ack); end
      checks++; if (arb.gnt !== 4'b0000) begin errors++; $display("FAIL wr_c2_gnt: got %b want 0000", arb.gnt); end
      checks++; if (arb.busy !== 1'b1) begin errors++; $display("FAIL wr_c2_busy: got %b want 1", arb.busy); end
      arb.req = 4'b0000;
      step();
      checks++; if (arb.ack !== 4'b0000) begin errors++; $display("FAIL wr_c3_ack: got %b want 0000", arb.ack); end
      checks++; if (arb.busy !== 1'b0) begin errors++; $display("FAIL wr_c3_busy: got %b want 0", arb.busy); end
      $display("write req0 data a5 done");
   endtask

   task automatic test_read();
      arb.req = 4'b0100; arb.wr = 4'b0000; tb_drv = 8'h3C;
      step();
      checks++; if (arb.gnt !== 4'b0100) begin errors++; $display("FAIL rd_c1_gnt: got %b want 0100", arb.gnt); end
      checks++; if (dut.w_oe !== 1'b0) begin errors++; $display("FAIL rd_c1_oe: got %b want 0", dut.w_oe); end
      checks++; if (arb.rvalid !== 1'b0) begin errors++; $display("FAIL rd_c1_rvalid: got %b want 0", arb.rvalid); end
      checks++; if (bus !== 8'h3C) begin errors++; $display("FAIL rd_c1_bus: got %h want 3c", bus); end
      step();
      checks++; if (arb.rdata !== 8'h3C) begin errors++; $display("FAIL rd_c2_rdata: got %h want 3c", arb.rdata); end
      checks++; if (arb.rvalid !== 1'b1) begin errors++; $display("FAIL rd_c2_rvalid: got %b want 1", arb.rvalid); end
      checks++; if (arb.ack !== 4'b0100) begin errors++; $display("FAIL rd_c2_ack: got %b want 0100", arb.ack); end
      checks++; if (arb.gnt !== 4'b0000) begin errors++; $display("FAIL rd_c2_gnt: got %b want 0000", arb.gnt); end
      arb.req = 4'b0000;
      step();
      checks++; if (arb.rvalid !== 1'b0) begin errors++; $display("FAIL rd_c3_rvalid: got %b want 0", arb.rvalid); end
      checks++; if (arb.ack !== 4'b0000) begin errors++; $display("FAIL rd_c3_ack: got %b want 0000", arb.ack); end
      checks++; if (arb.rdata !== 8'h3C) begin errors++; $display("FAIL rd_c3_hold: got %h want 3c", arb.rdata); end
      checks++; if (arb.gnt !== 4'b0000) begin errors++; $display("FAIL rd_c3_gnt: got %b want 0000", arb.gnt); end
      $display("read req2 data 3c done");
   endtask

   task automatic test_round_robin();
      logic [31:0] d;
      logic [3:0]  g;
      logic [7:0]  e;
      d = 32'h44332211;
      reset = 1'b1;
      step();
      reset = 1'b0;
      tb_oe = 1'b0;
      arb.req = 4'b1111; arb.wr = 4'b1111; arb.wdata = d;
      for (int k = 0; k < 5; k++) begin
         g = 4'b0001 << (k % 4);
         e = d[8*(k%4) +: 8];
         step();
         checks++; if (arb.gnt !== g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, arb.gnt, g); end
         checks++; if (bus !== e) begin errors++; $display("FAIL rr_bus[%0d]: got %h want %h", k, bus, e); end
         step();
         checks++; if (arb.ack !== g) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", k, arb.ack, g); end
         checks++; if (dut.w_oe !== 1'b0) begin errors++; $display("FAIL rr_turn_oe[%0d]: got %b want 0", k, dut.w_oe); end
         if (k == 4) arb.req = 4'b0000;
         step();
         checks++; if (arb.busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got busy %b want 0", k, arb.busy); end
         $display("round robin write req%0d data %h done", k % 4, e);
      end
      tb_oe = 1'b1;
   endtask

   task automatic test_back_to_back();
      arb.req = 4'b0110; arb.wr = 4'b0010; arb.wdata = 32'h00007700;
      tb_oe = 1'b0;
      step();
      checks++; if (arb.gnt !== 4'b0010) begin errors++; $display("FAIL b2b_wgnt: got %b want 0010", arb.gnt); end
      checks++; if (bus !== 8'h77) begin errors++; $display("FAIL b2b_wbus: got %h want 77", bus); end
      step();
      checks++; if (arb.ack !== 4'b0010) begin errors++; $display("FAIL b2b_wack: got %b want 0010", arb.ack); end
      arb.req = 4'b0100; tb_oe = 1'b1; tb_drv = 8'hC3;
      #1;
      checks++; if (bus !== 8'hC3) begin errors++; $display("FAIL b2b_turn_bus: got %h want c3", bus); end
      step();
      checks++; if (arb.gnt !== 4'b0000) begin errors++; $display("FAIL b2b_idle_gnt: got %b want 0000", arb.gnt); end
      checks++; if (arb.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", arb.busy); end
      step();
      checks++; if (arb.gnt !== 4'b0100) begin errors++; $display("FAIL b2b_rgnt: got %b want 0100", arb.gnt); end
      checks++; if (dut.w_oe !== 1'b0) begin errors++; $display("FAIL b2b_read_oe: got %b want 0", dut.w_oe); end
      checks++; if (bus !== 8'hC3) begin errors++; $display("FAIL b2b_read_bus: got %h want c3", bus); end
      step();
      checks++; if (arb.ack !== 4'b0100) begin errors++; $display("FAIL b2b_rack: got %b want 0100", arb.ack); end
      checks++; if (arb.rdata !== 8'hC3) begin errors++; $display("FAIL b2b_rdata: got %h want c3", arb.rdata); end
      arb.req = 4'b0000;
      step();
      $display("write req1 then read req2 done");
   endtask

   task automatic test_async_reset();
      arb.req = 4'b0001; arb.wr = 4'b0001; arb.wdata = 32'h000000FF;
      tb_oe = 1'b0;
      step();
      checks++; if (bus !== 8'hFF) begin errors++; $display("FAIL ar_wbus: got %h want ff", bus); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (dut.w_oe !== 1'b0) begin errors++; $display("FAIL ar_oe: got %b want 0", dut.w_oe); end
      checks++; if (arb.gnt !== 4'b0000) begin errors++; $display("FAIL ar_gnt: got %b want 0000", arb.gnt); end
      tb_oe = 1'b1; tb_drv = 8'h5A; arb.req = 4'b0000;
      #1;
      checks++; if (bus !== 8'h5A) begin errors++; $display("FAIL ar_bus: got %h want 5a", bus); end
      step();
      checks++; if (arb.ack !== 4'b0000) begin errors++; $display("FAIL ar_noack: got %b want 0000", arb.ack); end
      reset = 1'b0;
      arb.req = 4'b0011; arb.wr = 4'b0000;
      step();
      checks++; if (arb.gnt !== 4'b0001) begin errors++; $display("FAIL ar_first: got %b want 0001", arb.gnt); end
      step();
      checks++; if (arb.ack !== 4'b0001) begin errors++; $display("FAIL ar_ack0: got %b want 0001", arb.ack); end
      checks++; if (arb.rdata !== 8'h5A) begin errors++; $display("FAIL ar_rdata: got %h want 5a", arb.rdata); end
      arb.req = 4'b0010;
      step();
      checks++; if (arb.gnt !== 4'b0010) begin errors++; $display("FAIL ar_second: got %b want 0010", arb.gnt); end
      step();
      checks++; if (arb.ack !== 4'b0010) begin errors++; $display("FAIL ar_ack1: got %b want 0010", arb.ack); end
      arb.req = 4'b0000;
      step();
      $display("async reset during write done");
   endtask

   task automatic test_drop_during_read();
      arb.req = 4'b1000; arb.wr = 4'b0000; tb_drv = 8'h99;
      step();
      checks++; if (arb.gnt !== 4'b1000) begin errors++; $display("FAIL dr_gnt: got %b want 1000", arb.gnt); end
      arb.req = 4'b0000;
      step();
      checks++; if (arb.ack !== 4'b1000) begin errors++; $display("FAIL dr_ack: got %b want 1000", arb.ack); end
      checks++; if (arb.rvalid !== 1'b1) begin errors++; $display("FAIL dr_rvalid: got %b want 1", arb.rvalid); end
      checks++; if (arb.rdata !== 8'h99) begin errors++; $display("FAIL dr_rdata: got %h want 99", arb.rdata); end
      step();
      checks++; if (arb.ack !== 4'b0000) begin errors++; $display("FAIL dr_ack_once: got %b want 0000", arb.ack); end
      checks++; if (arb.rvalid !== 1'b0) begin errors++; $display("FAIL dr_rvalid_once: got %b want 0", arb.rvalid); end
      step();
      checks++; if (arb.gnt !== 4'b0000) begin errors++; $display("FAIL dr_regrant: got %b want 0000", arb.gnt); end
      checks++; if (arb.busy !== 1'b0) begin errors++; $display("FAIL dr_busy: got %b want 0", arb.busy); end
      $display("read req3 with early req drop done");
   endtask

   initial begin
      reset = 1'b1;
      tb_oe = 1'b1; tb_drv = 8'h5A;
      arb.req = '0; arb.wr = '0; arb.wdata = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_back_to_back();
      test_async_reset();
      test_drop_during_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Shares one bidirectional WIDTH-bit tristate bus between NREQ requesters.
- Each requester either writes, with the arbiter driving the bus, or reads, with the bus released and sampled.
- Round-robin grant; one idle turnaround cycle after every write, so the arbiter never contends with an external driver.
- Sits between the register/counter datapath blocks and a shared external inout pin group; it is the sequencing owner of the bus output enable.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, bus and data width in bits.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until its ack.
- wr  input  NREQ  per-requester direction: 1 = write, 0 = read. Sampled at grant.
- wdata  input  NREQ*WIDTH  packed write data; slice i belongs to requester i. Sampled at grant.
- bus  inout  WIDTH  shared tristate bus; driven only in WRITE state, high-Z otherwise.
- gnt  output  NREQ  one-hot registered grant; high through WRITE/READ.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- rdata  output  WIDTH  last sampled read value; holds until the next read.
- rvalid  output  1  one-cycle pulse coincident with ack of a read.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, bus high-Z (oe=0), gnt=0, ack=0, rvalid=0, rdata=0, busy=0, ptr=NREQ-1 so requester 0 wins first.
- States: IDLE, WRITE, READ, TURN. Encoding in package.
- IDLE:
  - Effective request = req & ~ack. This masks the requester being acked this cycle.
  - If effective request is nonzero: pick the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - Register gnt=onehot(winner), owner=winner, ptr=winner, dlat=wdata[winner].
  - Next state: WRITE if wr[winner], else READ.
- WRITE (1 cycle): oe=1, bus=dlat, gnt held. Next state TURN; ack[owner] registered high for the TURN cycle.
- TURN (1 cycle): oe=0, gnt=0, ack[owner]=1. Next state IDLE. No arbitration in TURN.
- READ (1 cycle): oe=0, gnt held. At the closing edge: rdata<=bus, ack[owner]<=1, rvalid<=1, gnt<=0, state<=IDLE. Arbitration may happen in that same IDLE cycle, with the acked requester masked.
- Latency from req seen in IDLE at cycle N:
  - Write: bus driven in N+1, ack in N+2, next grant decision in N+3.
  - Read: bus sampled at end of N+1, ack/rvalid/rdata in N+2, next grant decision in N+2.
- Direction and data are captured at grant. Changes to wr/wdata while granted are ignored.
- req dropped by the owner while granted: the transaction still completes and ack still pulses.
- bus high-Z during READ with no external driver: rdata captures whatever the simulator resolves. No error flag.
- Only one requester is ever granted; gnt and ack are always one-hot or zero; ack and gnt are never both high for the same requester.
- Fairness: a continuously requesting requester is granted within NREQ transactions.
- Reset mid-WRITE releases the bus asynchronously in the same cycle; no ack is issued for the aborted transaction.

Decomposition:
- Package tri_arb_pkg holds:
  - state enum typedef (IDLE, WRITE, READ, TURN), 2 bits;
  - default WIDTH/NREQ constants;
  - the onehot helper function.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; outputs are winner index and valid. Parameterised by NREQ.
- The tristate assignment (bus = oe ? dlat : 'z) stays in the top level.

Test Plan:
- Reset, then req=4'b0001, wr=1, wdata[0]=8'hA5 → gnt=0001 in cycle 1, bus=8'hA5 only in cycle 1, ack=0001 in cycle 2, bus=Z in cycles 0 and 2, busy high cycles 1-2.
- Bench drives bus=8'h3C while req[2] read (wr=0) → gnt=0100 for one cycle, then rdata=8'h3C with rvalid=1, ack=0100 the next cycle.
- req=4'b1111 all writes held continuously, with wdata slices 11/22/33/44 → grant order 0,1,2,3,0; bus shows 11,22,33,44,11 on every third cycle; TURN between each.
- Requester 1 write followed immediately by requester 2 read, both pending → bus driven by the arbiter in write cycle; TURN cycle high-Z; READ starts no earlier than 2 cycles after the write cycle; no cycle with oe=1 during READ.
- Assert reset asynchronously mid-WRITE (wdata=8'hFF) → bus goes Z before the next clk edge; gnt=0, no ack; after release, req[0] is granted first.
- Owner drops req during READ → ack/rvalid still pulse once; no re-grant of that requester.
